vcsr_cfg_loader: RTL and testbench
==================================

// Module: vcsr_cfg_loader
// PURPOSE
//  Boot/reload sequencer for the VCSR config bank. After reset, or on a reload request, it walks an external
//  config table and programs config CSRs VcsrBase .. VcsrBase+VcsrAmount-1 with CSRRW writes. Outside a load
//  it passes the core's CSR port straight through, so it owns the csr_* inputs of the vcsr block.
// PARAMETERS
//  VcsrAmount  config_pkg value (16)  number of config entries to program
//  VcsrBase    config_pkg value ('h100)  CSR address of config entry 0
// PORTS
//  clk            in   1   clock
//  reset          in   1   asynchronous, active-low reset
//  reload_req     in   1   1-cycle pulse: start a full table reload (honoured only in PASS)
//  tbl_addr       out  $clog2(VcsrAmount)  table read index
//  tbl_rd         out  1   table read strobe; data is valid the cycle after
//  tbl_data       in   32  table read data: a config_entry_t image {addr, offset, width}
//  core_csr_enable in  1   core CSR request
//  core_csr_addr  in   12  core CSR address (CsrAddrT)
//  core_csr_op    in   csr_op_t  core CSR op
//  core_rs1_zimm  in   5   core zimm
//  core_rs1_data  in   32  core rs1 data
//  core_stall     out  1   core must hold its CSR request
//  csr_enable     out  1   to vcsr / csr bank
//  csr_addr       out  12  to vcsr / csr bank
//  csr_op         out  csr_op_t  to vcsr / csr bank
//  rs1_zimm       out  5   to vcsr / csr bank
//  rs1_data       out  32  to vcsr / csr bank
//  busy           out  1   load in progress
//  load_done      out  1   1-cycle pulse at the end of each load
// BEHAVIOUR
//  States: LOAD_RD, LOAD_WR, PASS. The index counter k has width $clog2(VcsrAmount).
//  Reset asserted (reset==0): state=LOAD_RD, k=0, load_done=0. During reset, and in the first cycle after
//   release, busy=1 and core_stall=1.
//  LOAD_RD: tbl_rd=1, tbl_addr=k; csr_enable=0; next state LOAD_WR.
//  LOAD_WR: csr_enable=1, csr_addr=VcsrBase+k (12-bit add, no wrap within range), csr_op=CSRRW,
//   rs1_data=tbl_data, rs1_zimm=0, tbl_rd=0.
//   - If k==VcsrAmount-1: go to PASS, k=0, load_done=1 in the next cycle only.
//   - Otherwise k=k+1 and go to LOAD_RD.
//  Load length: exactly 2*VcsrAmount cycles. A write to entry k lands in LOAD_WR cycle 2k+1, counting from
//   0 at the first LOAD_RD.
//  LOAD_* states: busy=1, core_stall=1. core_* inputs are ignored, so no core access is ever dropped or
//   merged (the core holds its request).
//  PASS: busy=0, core_stall=0, tbl_rd=0. csr_* equal core_* combinationally (zero latency).
//  reload_req in PASS:
//   - Next state LOAD_RD with k=0.
//   - A core access in the same cycle is still passed through that cycle.
//  reload_req in LOAD_*: ignored; the current load continues and no restart occurs.
//  Reset mid-load: restart from k=0. Partially written entries are simply rewritten.
//  In non-pass states, outputs not listed above are 0 (csr_addr=0 when csr_enable=0).
//  csr_addr never targets the vcsr range VcsrBase+VcsrAmount .. VcsrBase+2*VcsrAmount-1 during a load.
// TESTING
//  1. VcsrAmount=4; table[k]=32'hA0+k; release reset -> writes (0x100,A0),(0x101,A1),(0x102,A2),(0x103,A3)
//     in cycles 1,3,5,7; load_done in cycle 8; busy falls in cycle 8.
//  2. In PASS, core writes 0x105 with CSRRS and data 0x5 -> csr_* mirror it in the same cycle; core_stall=0.
//  3. Core request held during load -> csr_enable never carries core_*; the request passes in the first PASS
//     cycle.
//  4. reload_req coincident with a core access in PASS -> core access is passed through; reload writes
//     0x100..0x103 follow; load_done fires once.
//  5. reset pulsed low after the write to 0x101 -> no further writes until release, then the full sequence
//     restarts at 0x100.
//  6. reload_req pulsed during LOAD_WR of k=2 -> ignored; exactly one load_done; no extra writes.

Source files
------------

// File: rtl/vcsr_cfg_loader.sv
// VCSR config loader: walks the config table into VcsrBase.. (2 cycles/entry) after reset or reload_req,
// otherwise zero-latency core CSR pass-through; core_stall holds the core for the whole load.
package config_pkg;
  localparam int          VcsrAmount = 16;
  localparam logic [11:0] VcsrBase   = 12'h100;

  typedef logic [11:0] CsrAddrT;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSRRW    = 2'b01,
    CSRRS    = 2'b10,
    CSRRC    = 2'b11
  } csr_op_t;
endpackage

module vcsr_cfg_loader #(
  parameter int          VcsrAmount = config_pkg::VcsrAmount,
  parameter logic [11:0] VcsrBase   = config_pkg::VcsrBase,
  localparam int         KW         = (VcsrAmount > 1) ? $clog2(VcsrAmount) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reload_req,
  output logic [KW-1:0]       tbl_addr,
  output logic                tbl_rd,
  input  logic [31:0]         tbl_data,
  input  logic                core_csr_enable,
  input  config_pkg::CsrAddrT core_csr_addr,
  input  config_pkg::csr_op_t core_csr_op,
  input  logic [4:0]          core_rs1_zimm,
  input  logic [31:0]         core_rs1_data,
  output logic                core_stall,
  output logic                csr_enable,
  output config_pkg::CsrAddrT csr_addr,
  output config_pkg::csr_op_t csr_op,
  output logic [4:0]          rs1_zimm,
  output logic [31:0]         rs1_data,
  output logic                busy,
  output logic                load_done
);

  typedef enum logic [1:0] {
    LOAD_RD = 2'b00,
    LOAD_WR = 2'b01,
    PASS    = 2'b10
  } state_t;

  localparam logic [KW-1:0] KLast = KW'(VcsrAmount - 1);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          last_k;

  assign last_k = (k_q == KLast);

  // Reset parks in LOAD_RD so busy/core_stall are already high while reset is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD_RD;
      k_q       <= '0;
      load_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      load_done <= (state_q == LOAD_WR) && last_k;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    busy       = 1'b1;
    core_stall = 1'b1;
    tbl_rd     = 1'b0;
    tbl_addr   = '0;
    csr_enable = 1'b0;
    csr_addr   = '0;
    csr_op     = config_pkg::CSR_NONE;
    rs1_zimm   = '0;
    rs1_data   = '0;
    unique case (state_q)
      LOAD_RD: begin
        tbl_rd   = 1'b1;
        tbl_addr = k_q;
        state_d  = LOAD_WR;
      end
      LOAD_WR: begin
        // Table data requested in LOAD_RD arrives this cycle and is written straight through.
        csr_enable = 1'b1;
        csr_addr   = VcsrBase + 12'(k_q);
        csr_op     = config_pkg::CSRRW;
        rs1_data   = tbl_data;
        if (last_k) begin
          state_d = PASS;
          k_d     = '0;
        end else begin
          state_d = LOAD_RD;
          k_d     = k_q + 1'b1;
        end
      end
      PASS: begin
        busy       = 1'b0;
        core_stall = 1'b0;
        csr_enable = core_csr_enable;
        csr_addr   = core_csr_addr;
        csr_op     = core_csr_op;
        rs1_zimm   = core_rs1_zimm;
        rs1_data   = core_rs1_data;
        if (reload_req) begin
          state_d = LOAD_RD;
          k_d     = '0;
        end
      end
      default: begin
        state_d = LOAD_RD;
        k_d     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_vcsr_cfg_loader.sv
// Bench for vcsr_cfg_loader (4 entries): cycle-indexed load model, pass-through vector table, corner sequences.
module tb_vcsr_cfg_loader;
  import config_pkg::*;

  localparam int          N    = 4;
  localparam logic [11:0] BASE = 12'h100;

  logic        clk = 1'b0;
  logic        reset, reload_req;
  logic [1:0]  tbl_addr;
  logic        tbl_rd;
  logic [31:0] tbl_data = '0;
  logic        core_csr_enable;
  logic [11:0] core_csr_addr;
  csr_op_t     core_csr_op;
  logic [4:0]  core_rs1_zimm;
  logic [31:0] core_rs1_data;
  logic        core_stall, csr_enable, busy, load_done;
  logic [11:0] csr_addr;
  csr_op_t     csr_op;
  logic [4:0]  rs1_zimm;
  logic [31:0] rs1_data;

  always #5 clk = ~clk;

  vcsr_cfg_loader #(.VcsrAmount(N), .VcsrBase(BASE)) dut (
    .clk(clk), .reset(reset), .reload_req(reload_req),
    .tbl_addr(tbl_addr), .tbl_rd(tbl_rd), .tbl_data(tbl_data),
    .core_csr_enable(core_csr_enable), .core_csr_addr(core_csr_addr), .core_csr_op(core_csr_op),
    .core_rs1_zimm(core_rs1_zimm), .core_rs1_data(core_rs1_data), .core_stall(core_stall),
    .csr_enable(csr_enable), .csr_addr(csr_addr), .csr_op(csr_op),
    .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .busy(busy), .load_done(load_done)
  );

  // Config table memory: one-cycle read latency
  logic [31:0] tbl_mem [N];
  always @(posedge clk) if (tbl_rd) tbl_data <= tbl_mem[tbl_addr];

  int checks = 0;
  int errors = 0;
  int c = 0;          // cycle index inside a load (2k = table read, 2k+1 = write of entry k); -1 = passing
  bit done_exp = 1'b0;
  int wr_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic rld, input logic en, input logic [11:0] a,
                       input csr_op_t op, input logic [4:0] z, input logic [31:0] d);
    logic [51:0] e_csr;
    logic        e_busy, e_rd;
    @(posedge clk);
    #2;
    reset = rst; reload_req = rld; core_csr_enable = en; core_csr_addr = a;
    core_csr_op = op; core_rs1_zimm = z; core_rs1_data = d;
    if (!rst) begin c = 0; done_exp = 1'b0; end
    @(negedge clk);
    e_busy = (c >= 0);
    e_rd   = (c >= 0) && (c % 2 == 0);
    if (c < 0)           e_csr = {en, a, op, z, d};
    else if (c % 2 == 1) e_csr = {1'b1, BASE + 12'(c / 2), CSRRW, 5'd0, tbl_mem[c / 2]};
    else                 e_csr = '0;
    chk("ctl{busy,stall,done,rd}", {busy, core_stall, load_done, tbl_rd}, {e_busy, e_busy, done_exp, e_rd});
    if (e_rd) chk("tbl_addr", 64'(tbl_addr), 64'(c / 2));
    chk("csr{en,addr,op,zimm,data}", {csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data}, e_csr);
    if (csr_enable && busy) wr_cnt++;
    if (load_done) done_cnt++;
    if (!rst) c = 0;
    else if (c >= 0) begin
      if (c == 2 * N - 1) begin c = -1; done_exp = 1'b1; end
      else begin c++; done_exp = 1'b0; end
    end else begin
      done_exp = 1'b0;
      if (rld) c = 0;
    end
  endtask

  task automatic idle(input logic rld);
    cycle(1'b1, rld, 1'b0, 12'h0, CSR_NONE, 5'd0, 32'd0);
  endtask

  typedef struct {
    logic en; logic [11:0] a; csr_op_t op; logic [4:0] z; logic [31:0] d;
    logic e_en; logic [11:0] e_a; csr_op_t e_op; logic [4:0] e_z; logic [31:0] e_d; logic e_stall;
  } vec_t;

  vec_t vecs [5];

  initial begin
    reset = 1'b0; reload_req = 1'b0; core_csr_enable = 1'b0; core_csr_addr = '0;
    core_csr_op = CSR_NONE; core_rs1_zimm = '0; core_rs1_data = '0;
    for (int k = 0; k < N; k++) tbl_mem[k] = 32'hA0 + k;

    vecs[0] = '{1'b1, 12'h105, CSRRS, 5'd0,  32'h5,        1'b1, 12'h105, CSRRS, 5'd0,  32'h5,        1'b0};
    vecs[1] = '{1'b1, 12'h100, CSRRW, 5'd3,  32'hDEADBEEF, 1'b1, 12'h100, CSRRW, 5'd3,  32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 12'hFFF, CSRRC, 5'd31, 32'hFFFFFFFF, 1'b1, 12'hFFF, CSRRC, 5'd31, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{1'b0, 12'h103, CSRRS, 5'd7,  32'h12345678, 1'b0, 12'h103, CSRRS, 5'd7,  32'h12345678, 1'b0};
    vecs[4] = '{1'b1, 12'h000, CSR_NONE, 5'd1, 32'h0,      1'b1, 12'h000, CSR_NONE, 5'd1, 32'h0,      1'b0};

    // Reset held, then release: writes in cycles 1,3,5,7, done/busy fall in cycle 8
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 12'h0, CSR_NONE, 5'd0, 32'd0);
    wr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      if (i == 1) chk("t1_first_write", {csr_enable, csr_addr, rs1_data}, {1'b1, 12'h100, 32'hA0});
      if (i == 7) chk("t1_last_write", {csr_enable, csr_addr, rs1_data}, {1'b1, 12'h103, 32'hA3});
      if (i == 8) chk("t1_cycle8_busy_done", {busy, load_done}, 2'b01);
    end
    chk("t1_writes", 64'(wr_cnt), 64'd4);
    chk("t1_done_pulses", 64'(done_cnt), 64'd1);

    // Pass-through vectors
    foreach (vecs[i]) begin
      cycle(1'b1, 1'b0, vecs[i].en, vecs[i].a, vecs[i].op, vecs[i].z, vecs[i].d);
      chk("vec_pass", {csr_enable, csr_addr, csr_op, rs1_zimm, rs1_data, core_stall},
          {vecs[i].e_en, vecs[i].e_a, vecs[i].e_op, vecs[i].e_z, vecs[i].e_d, vecs[i].e_stall});
    end

    // Reload coincident with a core access, core request then held through the load
    for (int k = 0; k < N; k++) tbl_mem[k] = $urandom;
    wr_cnt = 0; done_cnt = 0;
    cycle(1'b1, 1'b1, 1'b1, 12'h105, CSRRS, 5'd0, 32'h5);
    chk("t4_coincident_pass", {csr_enable, csr_addr, csr_op, core_stall}, {1'b1, 12'h105, CSRRS, 1'b0});
    for (int i = 0; i < 2 * N; i++) cycle(1'b1, 1'b0, 1'b1, 12'h105, CSRRS, 5'd0, 32'h5);
    cycle(1'b1, 1'b0, 1'b1, 12'h105, CSRRS, 5'd0, 32'h5);
    chk("t3_held_req_passes", {csr_enable, csr_addr, rs1_data, core_stall, load_done},
        {1'b1, 12'h105, 32'h5, 1'b0, 1'b1});
    idle(1'b0);
    chk("t4_writes", 64'(wr_cnt), 64'd4);
    chk("t4_done_pulses", 64'(done_cnt), 64'd1);

    // Reset pulsed after the write to 0x101, then full restart
    idle(1'b1);
    for (int i = 0; i < 4; i++) idle(1'b0);
    cycle(1'b0, 1'b0, 1'b0, 12'h0, CSR_NONE, 5'd0, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 12'h0, CSR_NONE, 5'd0, 32'd0);
    chk("t5_no_write_in_reset", {csr_enable, busy, load_done}, 3'b010);
    wr_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b0);
      if (i == 1) chk("t5_restart_addr", {csr_enable, csr_addr}, {1'b1, 12'h100});
    end
    chk("t5_writes", 64'(wr_cnt), 64'd4);
    chk("t5_done_pulses", 64'(done_cnt), 64'd1);

    // Reload pulsed during the write of entry 2 is ignored
    wr_cnt = 0; done_cnt = 0;
    idle(1'b1);
    for (int i = 0; i < 5; i++) idle(1'b0);
    idle(1'b1);
    chk("t6_in_wr_k2", {csr_enable, csr_addr}, {1'b1, 12'h102});
    for (int i = 0; i < 8; i++) idle(1'b0);
    chk("t6_writes", 64'(wr_cnt), 64'd4);
    chk("t6_done_pulses", 64'(done_cnt), 64'd1);

    // Randomized traffic, reloads and resets against the model
    for (int i = 0; i < 3000; i++) begin
      if (c < 0 && $urandom_range(0, 7) == 0) tbl_mem[$urandom_range(0, N - 1)] = $urandom;
      cycle($urandom_range(0, 149) != 0, $urandom_range(0, 15) == 0, 1'($urandom),
            12'($urandom), csr_op_t'($urandom_range(0, 3)), 5'($urandom), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
